dmem_bus_bridge: RTL and testbench
==================================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the core's MEM stage; replaces the zero-latency on-core data memory path.
- Accepts the MEM-stage access (rd_en/wr_en/addr/wr_data/mask) and converts it into a valid/ready request plus response transaction on an external data bus.
- Holds the pipeline with stall_req until the transaction completes, then returns the read word to the MEM stage.

Parameters:
ADDR_W, 32, byte address width (matches MEM_ADDR_WIDTH)
DATA_W, 32, data word width (matches REG_DATA_WIDTH)
STRB_W, 4, byte-strobe width, DATA_W/8
TIMEOUT_CYCLES, 255, max WAIT_RSP cycles before forced error completion (only with timeout feature)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
core_rd_en  in  1  MEM-stage load request
core_wr_en  in  1  MEM-stage store request
core_addr  in  ADDR_W  byte address
core_wr_data  in  DATA_W  store data, already lane-aligned
core_strb  in  STRB_W  byte enables
core_rd_data  out  DATA_W  returned read word, valid while state==DONE
stall_req  out  1  hold all pipeline stages
acc_err  out  1  one-cycle pulse: access completed with error
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_W  word-aligned address, low 2 bits forced 0
bus_req_wdata  out  DATA_W  write data
bus_req_strb  out  STRB_W  byte enables, all-ones for reads
bus_rsp_valid  in  1  response valid, single cycle
bus_rsp_rdata  in  DATA_W  read data, ignored for writes
bus_rsp_err  in  1  response error flag
stall_cycles  out  32  saturating count of cycles with stall_req=1

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs 0, including bus_req_valid, stall_req, core_rd_data and stall_cycles.
  - Reset mid-transaction abandons the transaction; bus_req_valid drops immediately.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - If core_rd_en|core_wr_en: stall_req=1 combinationally in the same cycle.
  - Capture addr/wdata/strb/we into request registers; go to REQ.
  - core_rd_en and core_wr_en both high: treated as a write.
- REQ:
  - bus_req_valid=1; fields driven from the captured registers and stable until handshake.
  - On bus_req_ready=1: go to WAIT_RSP.
  - stall_req=1.
- WAIT_RSP:
  - stall_req=1.
  - On bus_rsp_valid: latch rdata (0 if bus_rsp_err or a write), latch err, go to DONE.
- DONE:
  - stall_req=0 for exactly one cycle; the pipeline advances at the following edge.
  - core_rd_data holds the latched word; acc_err = latched err.
  - Always goes to IDLE. The request still visible this cycle is the completed one and must not be reissued.
- Latency: minimum 3 cycles of stall (IDLE, REQ with ready=1, WAIT_RSP with rsp_valid=1), then DONE.
- Back-to-back accesses: one IDLE cycle between DONE and the next capture.
- Bus protocol:
  - Minimum response latency is one cycle after the request handshake.
  - bus_rsp_valid outside WAIT_RSP is dropped.
- core_rd_data:
  - Holds its value outside DONE; updates only on response latch.
  - MEM stage performs lane extraction and sign extension.
- stall_cycles: +1 each cycle stall_req=1; saturates at 0xFFFF_FFFF.
- No access request: bridge idle, stall_req=0, no bus activity.

Optional Feature:
- Macro DMEM_BUS_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on entry to WAIT_RSP, incremented each WAIT_RSP cycle.
  - On reaching TIMEOUT_CYCLES without bus_rsp_valid: go to DONE with rdata=0 and err=1 (acc_err pulses).
  - A late response is dropped only if it arrives before the next request handshake.
- Not defined: no counter; WAIT_RSP waits indefinitely.

Decomposition:
- Shared package dmem_bus_pkg:
  - state enum (IDLE/REQ/WAIT_RSP/DONE)
  - STRB_W constant
  - ALL_STRB all-ones constant
  - typedef struct for the captured request {we, addr, wdata, strb}
- Single module; the timeout counter is small enough to stay inline, so there is no sub-module.

Test Plan:
- Load, addr=0x0000_0106, ready immediate, rsp after 2 cycles rdata=0x1122_3344 -> bus_req_addr=0x104, strb=0xF, we=0; stall_req high 4 cycles; DONE core_rd_data=0x1122_3344, acc_err=0.
- Store, addr=0x20, wdata=0xAB00_0000, strb=0x8, ready delayed 3 cycles -> bus_req fields stable across all 4 valid cycles; one handshake; no rdata update.
- Two loads back-to-back -> exactly two bus handshakes; one IDLE cycle between DONE and the second REQ; no duplicate issue.
- Response with bus_rsp_err=1 -> core_rd_data=0, acc_err pulses exactly one cycle, then IDLE.
- rst asserted during WAIT_RSP -> outputs 0 asynchronously; stall_cycles=0; a subsequent rsp_valid while IDLE is ignored.
- With DMEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=10, no response -> DONE 10 cycles after the handshake, acc_err=1, stall_cycles incremented by 12.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the MEM-stage to external data bus bridge.
// Optional wait-response timeout is enabled in the bridge with DMEM_BUS_TIMEOUT_EN.
package dmem_bus_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int STRB_W     = REQ_DATA_W / 8;
    localparam logic [STRB_W-1:0] ALL_STRB = {STRB_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [STRB_W-1:0]     strb;
    } req_t;

    function automatic logic [REQ_ADDR_W-1:0] word_align(input logic [REQ_ADDR_W-1:0] byte_addr);
        return {byte_addr[REQ_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_bus_bridge.sv
// Converts a MEM-stage load/store into a valid/ready request plus response on the data bus,
// stalling the pipeline until completion. Define DMEM_BUS_TIMEOUT_EN for a bounded response wait.
module dmem_bus_bridge
    import dmem_bus_pkg::*;
#(
    parameter int ADDR_W         = REQ_ADDR_W,
    parameter int DATA_W         = REQ_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic [STRB_W-1:0] core_strb,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              stall_req,
    output logic              acc_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic [STRB_W-1:0] bus_req_strb,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_rdata,
    input  logic              bus_rsp_err,
    output logic [31:0]       stall_cycles
);

    state_e            state_r;
    req_t              req_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              acc_err_r;
    logic [31:0]       stall_cnt_r;
    logic              stall_req_s;

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_r;
`endif

    // Stall decode: the IDLE term is combinational so the issuing instruction is held at once.
    always_comb begin
        stall_req_s = 1'b0;
        if (!rst) begin
            stall_req_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:     stall_req_s = core_rd_en | core_wr_en;
                REQ:      stall_req_s = 1'b1;
                WAIT_RSP: stall_req_s = 1'b1;
                DONE:     stall_req_s = 1'b0;
                default:  stall_req_s = 1'b0;
            endcase
        end
    end

    // Transaction FSM with captured request, latched read word and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            req_r     <= {$bits(req_t){1'b0}};
            rd_data_r <= {DATA_W{1'b0}};
            acc_err_r <= 1'b0;
`ifdef DMEM_BUS_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
`endif
        end else begin
            acc_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (core_rd_en | core_wr_en) begin
                        // Simultaneous load and store resolves to a store.
                        req_r.we    <= core_wr_en;
                        req_r.addr  <= word_align(core_addr);
                        req_r.wdata <= core_wr_data;
                        req_r.strb  <= core_wr_en ? core_strb : ALL_STRB;
                        state_r     <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        state_r <= WAIT_RSP;
`ifdef DMEM_BUS_TIMEOUT_EN
                        wait_cnt_r <= 8'd0;
`endif
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        rd_data_r <= (bus_rsp_err | req_r.we) ? {DATA_W{1'b0}} : bus_rsp_rdata;
                        acc_err_r <= bus_rsp_err;
                        state_r   <= DONE;
                    end
`ifdef DMEM_BUS_TIMEOUT_EN
                    else if (wait_cnt_r == TIMEOUT_LAST) begin
                        rd_data_r <= {DATA_W{1'b0}};
                        acc_err_r <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
`else
                    else begin
                        state_r <= WAIT_RSP;
                    end
`endif
                end
                // The request still presented here is the one just completed; never reissue it.
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_req_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_req     = stall_req_s;
    assign stall_cycles  = stall_cnt_r;
    assign core_rd_data  = rd_data_r;
    assign acc_err       = acc_err_r;
    assign bus_req_valid = (state_r == REQ);
    assign bus_req_we    = req_r.we;
    assign bus_req_addr  = req_r.addr;
    assign bus_req_wdata = req_r.wdata;
    assign bus_req_strb  = req_r.strb;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed self-checking bench for dmem_bus_bridge; the timeout scenario runs only with DMEM_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_rd_en = 1'b0;
    logic        core_wr_en = 1'b0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wr_data = 32'd0;
    logic [3:0]  core_strb = 4'd0;
    logic [31:0] core_rd_data;
    logic        stall_req;
    logic        acc_err;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_strb;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = 32'd0;
    logic        bus_rsp_err = 1'b0;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_total = 0;

    // Observations from the last access
    int          obs_stall, obs_valid, obs_unstable, obs_err_cyc, obs_first_v, obs_wait;
    logic        obs_timeout, obs_err, obs_we;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_strb;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst),
        .core_rd_en(core_rd_en), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_strb(core_strb), .core_rd_data(core_rd_data),
        .stall_req(stall_req), .acc_err(acc_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_req_valid && bus_req_ready) hs_total <= hs_total + 1;
    end

    // Drives one access from posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE after DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input int ready_dly, input int rsp_dly,
                             input logic [31:0] rdata, input logic err);
        int vcnt, wcnt, cyc;
        logic hs, done;
        vcnt = 0; wcnt = 0; cyc = 0; hs = 1'b0; done = 1'b0;
        obs_stall = 0; obs_valid = 0; obs_unstable = 0; obs_err_cyc = 0; obs_first_v = -1;
        obs_wait = 0; obs_timeout = 1'b0; obs_err = 1'b0; obs_rdata = 32'd0;
        obs_addr = 32'd0; obs_wdata = 32'd0; obs_strb = 4'd0; obs_we = 1'b0;
        core_rd_en = rd; core_wr_en = wr; core_addr = addr; core_wr_data = wdata; core_strb = strb;
        while (!done && cyc < 400) begin
            bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;
            if (bus_req_valid) begin
                vcnt++;
                if (vcnt > ready_dly) bus_req_ready = 1'b1;
            end else if (hs) begin
                wcnt++;
                if (wcnt == rsp_dly) begin
                    bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata; bus_rsp_err = err;
                end
            end
            @(negedge clk);
            if (stall_req) obs_stall++;
            if (acc_err) obs_err_cyc++;
            if (bus_req_valid) begin
                obs_valid++;
                if (obs_valid == 1) begin
                    obs_first_v = cyc;
                    obs_addr = bus_req_addr; obs_wdata = bus_req_wdata;
                    obs_strb = bus_req_strb; obs_we = bus_req_we;
                end else if (bus_req_addr !== obs_addr || bus_req_wdata !== obs_wdata ||
                             bus_req_strb !== obs_strb || bus_req_we !== obs_we) begin
                    obs_unstable++;
                end
            end
            if (hs && !stall_req) begin
                done = 1'b1; obs_rdata = core_rd_data; obs_err = acc_err; obs_wait = wcnt - 1;
            end
            if (bus_req_valid && bus_req_ready) hs = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) obs_timeout = 1'b1;
        core_rd_en = 1'b0; core_wr_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        core_rd_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
        n_tests++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus_req_valid); end
        n_tests++; if (core_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", core_rd_data); end
        n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
        n_tests++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL reset_acc_err got=%0b exp=0", acc_err); end
        @(posedge clk); #1;
        core_rd_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        int hs0;
        hs0 = hs_total;
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'hAB00_0000, 4'h8, 3, 1, 32'hDEAD_BEEF, 1'b0);
        n_tests++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL store_complete got_timeout=%0b exp=0", obs_timeout); end
        n_tests++; if (obs_valid !== 4) begin n_fail++; $display("FAIL store_valid_cycles got=%0d exp=4", obs_valid); end
        n_tests++; if (obs_unstable !== 0) begin n_fail++; $display("FAIL store_stable got=%0d exp=0", obs_unstable); end
        n_tests++; if (obs_addr !== 32'h0000_0020) begin n_fail++; $display("FAIL store_addr got=%h exp=00000020", obs_addr); end
        n_tests++; if (obs_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL store_wdata got=%h exp=ab000000", obs_wdata); end
        n_tests++; if (obs_strb !== 4'h8) begin n_fail++; $display("FAIL store_strb got=%h exp=8", obs_strb); end
        n_tests++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL store_we got=%0b exp=1", obs_we); end
        n_tests++; if (hs_total - hs0 !== 1) begin n_fail++; $display("FAIL store_handshakes got=%0d exp=1", hs_total - hs0); end
        n_tests++; if (obs_stall !== 6) begin n_fail++; $display("FAIL store_stall got=%0d exp=6", obs_stall); end
        n_tests++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL store_rdata got=%h exp=0", obs_rdata); end
        n_tests++; if (obs_err_cyc !== 0) begin n_fail++; $display("FAIL store_acc_err got=%0d exp=0", obs_err_cyc); end
        n_tests++; if (stall_cycles !== 32'd6) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=6", stall_cycles); end
    endtask

    task automatic test_load();
        do_access(1'b1, 1'b0, 32'h0000_0106, 32'h0, 4'h3, 0, 2, 32'h1122_3344, 1'b0);
        n_tests++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL load_complete got_timeout=%0b exp=0", obs_timeout); end
        n_tests++; if (obs_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL load_addr got=%h exp=00000104", obs_addr); end
        n_tests++; if (obs_strb !== 4'hF) begin n_fail++; $display("FAIL load_strb got=%h exp=f", obs_strb); end
        n_tests++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL load_we got=%0b exp=0", obs_we); end
        n_tests++; if (obs_stall !== 4) begin n_fail++; $display("FAIL load_stall got=%0d exp=4", obs_stall); end
        n_tests++; if (obs_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL load_rdata got=%h exp=11223344", obs_rdata); end
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL load_acc_err got=%0b exp=0", obs_err); end
        n_tests++; if (stall_cycles !== 32'd10) begin n_fail++; $display("FAIL load_stall_cycles got=%0d exp=10", stall_cycles); end
        @(negedge clk);
        n_tests++; if (core_rd_data !== 32'h1122_3344) begin n_fail++; $display("FAIL load_rdata_hold got=%h exp=11223344", core_rd_data); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL load_idle_stall got=%0b exp=0", stall_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int hs0;
        hs0 = hs_total;
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 1, 32'hA5A5_0001, 1'b0);
        n_tests++; if (obs_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_rdata0 got=%h exp=a5a50001", obs_rdata); end
        do_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 0, 1, 32'h5A5A_0002, 1'b0);
        n_tests++; if (obs_first_v !== 1) begin n_fail++; $display("FAIL b2b_idle_gap got=%0d exp=1", obs_first_v); end
        n_tests++; if (obs_valid !== 1) begin n_fail++; $display("FAIL b2b_valid_cycles got=%0d exp=1", obs_valid); end
        n_tests++; if (obs_rdata !== 32'h5A5A_0002) begin n_fail++; $display("FAIL b2b_rdata1 got=%h exp=5a5a0002", obs_rdata); end
        n_tests++; if (hs_total - hs0 !== 2) begin n_fail++; $display("FAIL b2b_handshakes got=%0d exp=2", hs_total - hs0); end
        n_tests++; if (stall_cycles !== 32'd16) begin n_fail++; $display("FAIL b2b_stall_cycles got=%0d exp=16", stall_cycles); end
    endtask

    task automatic test_reset_mid_wait();
        core_rd_en = 1'b1; core_addr = 32'h0000_0300;
        @(negedge clk);
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL rstw_in_wait got=%0b exp=1", stall_req); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rstw_stall got=%0b exp=0", stall_req); end
        n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rstw_stall_cycles got=%0d exp=0", stall_cycles); end
        n_tests++; if (core_rd_data !== 32'd0) begin n_fail++; $display("FAIL rstw_rdata got=%h exp=0", core_rd_data); end
        n_tests++; if (bus_req_addr !== 32'd0) begin n_fail++; $display("FAIL rstw_addr got=%h exp=0", bus_req_addr); end
        @(posedge clk); #1;
        core_rd_en = 1'b0;
        rst = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF; bus_rsp_err = 1'b1;
        @(negedge clk);
        n_tests++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_idle_valid got=%0b exp=0", bus_req_valid); end
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;
        @(negedge clk);
        n_tests++; if (core_rd_data !== 32'd0) begin n_fail++; $display("FAIL rstw_late_rsp_rdata got=%h exp=0", core_rd_data); end
        n_tests++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL rstw_late_rsp_err got=%0b exp=0", acc_err); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rstw_late_rsp_stall got=%0b exp=0", stall_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_error();
        do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, 1, 32'h55AA_55AA, 1'b1);
        n_tests++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL err_rdata got=%h exp=0", obs_rdata); end
        n_tests++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL err_acc_err got=%0b exp=1", obs_err); end
        n_tests++; if (obs_err_cyc !== 1) begin n_fail++; $display("FAIL err_pulse_len got=%0d exp=1", obs_err_cyc); end
        n_tests++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL err_stall_cycles got=%0d exp=3", stall_cycles); end
        @(negedge clk);
        n_tests++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_end got=%0b exp=0", acc_err); end
        n_tests++; if (stall_req !== 1'b0 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_idle got=%0b%0b exp=00", stall_req, bus_req_valid); end
        @(posedge clk); #1;
    endtask

`ifdef DMEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);
        n_tests++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL to_complete got_timeout=%0b exp=0", obs_timeout); end
        n_tests++; if (obs_wait !== 10) begin n_fail++; $display("FAIL to_wait_cycles got=%0d exp=10", obs_wait); end
        n_tests++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL to_acc_err got=%0b exp=1", obs_err); end
        n_tests++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL to_rdata got=%h exp=0", obs_rdata); end
        n_tests++; if (obs_stall !== 12) begin n_fail++; $display("FAIL to_stall got=%0d exp=12", obs_stall); end
        n_tests++; if (stall_cycles !== 32'd15) begin n_fail++; $display("FAIL to_stall_cycles got=%0d exp=15", stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid_wait();
        test_error();
`ifdef DMEM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
